demux_capture_8ch: RTL and testbench
====================================

# demux_capture_8ch

Downstream capture stage for the 1-to-8 demultiplexer tree. Samples the eight demux outputs bit-serially on a strobe, using the same select lines that steer the demux. Assembles a WORD-bit word per channel and hands completed words to the consumer one at a time. Handoff uses a round-robin valid/ack interface.

## Interface
Parameters:
- WORD, default 4: bits per channel word; legal range 2–16.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  asynchronous, active-high reset.
- Y0..Y7  input  1 each  demux outputs; only Y[{s2,s1,s0}] is meaningful.
- s0, s1, s2  input  1 each  channel select driven to the demux; channel index c = {s2,s1,s0}.
- strobe  input  1  bit-valid qualifier: Y[c] is sampled as one data bit on channel c on the rising clk edge where strobe=1.
- ack  input  1  consumer accepts the current word; meaningful only while valid=1.
- word  output  WORD  captured word, first-received bit in MSB.
- ch  output  3  channel index of word.
- valid  output  1  word/ch hold a completed word.
- overflow  output  8  sticky per-channel overrun flags, bit c for channel c.

## Operation
- Per channel c:
  - shift register sh[c] (WORD-1 bits),
  - bit counter cnt[c] (0..WORD-1),
  - holding register hold[c] (WORD bits),
  - pending flag pend[c].
- Strobe edge on channel c:
  - If cnt[c] < WORD-1: sh[c] <= {sh[c], Y[c]} and cnt[c]++.
  - If cnt[c] == WORD-1 (completing bit): hold[c] <= {sh[c], Y[c]}, pend[c] <= 1, cnt[c] <= 0.
  - The completing bit is the one that ends the word; there is no separate completion event.
- Non-selected Y inputs are ignored at all times. Without strobe, no channel state changes.
- Overrun: the completing bit arrives while pend[c]=1 and pend[c] is not being cleared in the same cycle.
  - The new word is dropped; hold[c] keeps the older word.
  - overflow[c] <= 1. It stays set until rst.
- Output register (word, ch, valid) loads when valid=0 or (valid=1 and ack=1):
  - If any pend is set, select the first set channel searching round-robin from last_ch+1 (mod 8).
  - word <= hold[sel], ch <= sel, valid <= 1, pend[sel] <= 0, last_ch <= sel.
  - If no pend is set, valid <= 0 and word/ch hold their previous values.
- ack while valid=0 is ignored.
- Same-edge events:
  - Channel c completes a word in the same cycle its pending word is loaded into the output register: pend[c] clears and re-sets to 1. hold[c] takes the new word. This is not an overrun.
  - Completion on channel c while another channel is being loaded: independent, both take effect.
- Reset mid-word or mid-handshake discards everything: partial bits, pending words and any unacknowledged output.

## Timing
- Reset values: word=0, ch=0, valid=0, overflow=8'h00. Internally: all cnt, sh, hold and pend = 0, last_ch=7, so channel 0 has first priority.
- Latency: completing strobe at edge k sets pend at k; valid=1 at edge k+1 if the output register is free.
- Throughput: one word per cycle when ack is held high with words pending.
- Handshake: word/ch/valid stay stable while valid=1 and ack=0.
- Transfer completes on an edge with valid=1 and ack=1. The next pending word appears on that same edge, with no bubble.
- Capacity: one word per channel in hold plus one in the output register.

## Test plan
- Reset then idle: valid=0, overflow=00, word=0 throughout. Asserting rst asynchronously mid-word clears partial state: after release, 4 fresh strobes on ch2 yield exactly one word.
- Single channel, WORD=4: strobe ch5 with bits 1,0,1,1 on edges 1–4, ack=1 → valid=1 on edge 5 with word=4'hB, ch=5. valid=0 on edge 6.
- Round-robin: complete words 4'h1 on ch1, 4'h3 on ch3 and 4'h6 on ch6 with ack=0 → first valid shows ch1. Asserting ack then gives ch3, then ch6, on consecutive cycles.
- Backpressure stability: hold ack=0 for 10 cycles with valid=1 → word and ch unchanged. Then complete 4'h5 and then 4'h9 on ch0 while ch0's earlier word is still pending → overflow=8'h01, 4'h9 is dropped and the pending word reads 4'h5.
- Same-edge completion: ch4 has a pending word 4'hA, and its output load coincides with the completing strobe of 4'hC on ch4 → overflow[4] stays 0, output shows 4'hA, then 4'hC after ack.
- Interleaved channels: alternate strobes between ch2 and ch7 with bits chosen to form 4'h3 on ch2 and 4'hE on ch7 → both words are assembled correctly without cross-contamination. Stray 1s on non-selected Y lines have no effect.

Source files
------------

// File: rtl/demux_capture_8ch.sv
// Capture stage behind the 1-to-8 demux: bit-serial word assembly per channel,
// one holding slot per channel, round-robin handoff over a valid/ack interface.
module demux_capture_8ch #(
    parameter int WORD = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Y0,
    input  logic            Y1,
    input  logic            Y2,
    input  logic            Y3,
    input  logic            Y4,
    input  logic            Y5,
    input  logic            Y6,
    input  logic            Y7,
    input  logic            s0,
    input  logic            s1,
    input  logic            s2,
    input  logic            strobe,
    input  logic            ack,
    output logic [WORD-1:0] word,
    output logic [2:0]      ch,
    output logic            valid,
    output logic [7:0]      overflow
);
    localparam int            CW   = $clog2(WORD);
    localparam logic [CW-1:0] LAST = CW'(WORD - 1);

    logic [7:0]      y_vec;
    logic [2:0]      sel_c;
    logic [WORD-1:0] shifted;
    logic            complete;
    logic            load;
    logic            grant_vld;
    logic [2:0]      grant;
    logic [2:0]      idx;
    logic            take_c;
    logic            overrun;
    logic [7:0]      pend_next;

    logic [WORD-2:0] sh   [8];
    logic [CW-1:0]   cnt  [8];
    logic [WORD-1:0] hold [8];
    logic [7:0]      pend;
    logic [2:0]      last_ch;

    assign y_vec    = {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0};
    assign sel_c    = {s2, s1, s0};
    assign shifted  = {sh[sel_c], y_vec[sel_c]};
    assign complete = strobe && (cnt[sel_c] == LAST);
    assign load     = !valid || ack;

    // Round-robin search starting just after the last channel served
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = '0;
        for (int i = 1; i <= 8; i++) begin
            idx = last_ch + 3'(i);
            if (!grant_vld && pend[idx]) begin
                grant     = idx;
                grant_vld = 1'b1;
            end
        end
    end

    // A channel whose pending word leaves on this edge may refill its slot at once
    assign take_c  = load && grant_vld && (grant == sel_c);
    assign overrun = complete && pend[sel_c] && !take_c;

    always_comb begin
        pend_next = pend;
        if (load && grant_vld)
            pend_next[grant] = 1'b0;
        if (complete && !overrun)
            pend_next[sel_c] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                sh[i]   <= '0;
                cnt[i]  <= '0;
                hold[i] <= '0;
            end
        end else if (strobe) begin
            if (complete) begin
                cnt[sel_c] <= '0;
                if (!overrun)
                    hold[sel_c] <= shifted;
            end else begin
                sh[sel_c]  <= shifted[WORD-2:0];
                cnt[sel_c] <= cnt[sel_c] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend     <= '0;
            overflow <= '0;
            word     <= '0;
            ch       <= '0;
            valid    <= 1'b0;
            last_ch  <= 3'd7;
        end else begin
            if (load) begin
                if (grant_vld) begin
                    word    <= hold[grant];
                    ch      <= grant;
                    valid   <= 1'b1;
                    last_ch <= grant;
                end else begin
                    valid <= 1'b0;
                end
            end
            pend <= pend_next;
            if (overrun)
                overflow[sel_c] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_demux_capture_8ch.sv
// Self-checking bench for demux_capture_8ch: directed scenarios followed by
// randomized traffic, all compared against a per-channel reference model.
module tb_demux_capture_8ch;
    localparam int WORD = 4;
    localparam int MASK = (1 << WORD) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            Y0 = 0, Y1 = 0, Y2 = 0, Y3 = 0, Y4 = 0, Y5 = 0, Y6 = 0, Y7 = 0;
    logic            s0 = 0, s1 = 0, s2 = 0;
    logic            strobe = 0;
    logic            ack = 0;
    logic [WORD-1:0] word;
    logic [2:0]      ch;
    logic            valid;
    logic [7:0]      overflow;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    int       m_acc  [8];
    int       m_cnt  [8];
    int       m_hold [8];
    bit       m_pend [8];
    int       m_last;
    int       m_word;
    int       m_ch;
    bit       m_valid;
    bit [7:0] m_ovf;

    demux_capture_8ch #(.WORD(WORD)) dut (
        .clk(clk), .rst(rst),
        .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3), .Y4(Y4), .Y5(Y5), .Y6(Y6), .Y7(Y7),
        .s0(s0), .s1(s1), .s2(s2),
        .strobe(strobe), .ack(ack),
        .word(word), .ch(ch), .valid(valid), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_acc[i] = 0; m_cnt[i] = 0; m_hold[i] = 0; m_pend[i] = 0;
        end
        m_last = 7; m_word = 0; m_ch = 0; m_valid = 0; m_ovf = '0;
    endtask

    // Words leave first (using the old holding value), then the new bit is absorbed.
    task automatic model_step(input bit stb, input int c, input bit b, input bit a);
        int sel;
        int nw;
        sel = -1;
        if (!m_valid || a) begin
            for (int k = 1; k <= 8; k++)
                if (sel < 0 && m_pend[(m_last + k) % 8]) sel = (m_last + k) % 8;
            if (sel >= 0) begin
                m_word = m_hold[sel]; m_ch = sel; m_valid = 1;
                m_pend[sel] = 0; m_last = sel;
            end else begin
                m_valid = 0;
            end
        end
        if (stb) begin
            if (m_cnt[c] < WORD - 1) begin
                m_acc[c] = m_acc[c] * 2 + int'(b);
                m_cnt[c]++;
            end else begin
                nw = (m_acc[c] * 2 + int'(b)) & MASK;
                m_acc[c] = 0; m_cnt[c] = 0;
                if (m_pend[c]) m_ovf[c] = 1'b1;
                else begin m_hold[c] = nw; m_pend[c] = 1; end
            end
        end
    endtask

    task automatic cyc(input bit stb, input int c, input bit b, input bit a);
        logic [7:0] yv;
        logic [2:0] cs;
        yv = 8'($urandom);
        cs = 3'(c);
        yv[cs] = b;
        {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0} = yv;
        {s2, s1, s0} = cs;
        strobe = stb;
        ack = a;
        @(posedge clk);
        model_step(stb, c, b, a);
        #1;
        chk("valid", valid, m_valid);
        chk("word", word, m_word);
        chk("ch", ch, m_ch);
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic send_word(input int c, input int w, input bit a);
        for (int i = WORD - 1; i >= 0; i--)
            cyc(1'b1, c, w[i], a);
    endtask

    task automatic async_reset();
        strobe = 0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_word", word, 0);
        chk("rst_ch", ch, 0);
        chk("rst_ovf", overflow, 0);
        model_reset();
        @(posedge clk);
        #3 rst = 1'b0;
    endtask

    initial begin
        int b3, be;
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        chk("reset_valid", valid, 0);
        chk("reset_word", word, 0);
        chk("reset_ch", ch, 0);
        chk("reset_ovf", overflow, 0);
        repeat (4) cyc(1'b0, 0, 1'b0, 1'b0);

        // single channel, bits 1,0,1,1 on ch5
        send_word(5, 'hB, 1'b1);
        chk("single_pre", valid, 0);
        cyc(1'b0, 0, 1'b0, 1'b1);
        chk("single_valid", valid, 1);
        chk("single_word", word, 'hB);
        chk("single_ch", ch, 5);
        cyc(1'b0, 0, 1'b0, 1'b1);
        chk("single_drop", valid, 0);

        // round-robin across ch1, ch3, ch6
        send_word(1, 1, 1'b0);
        send_word(3, 3, 1'b0);
        send_word(6, 6, 1'b0);
        chk("rr_first_ch", ch, 1);
        chk("rr_first_word", word, 1);
        cyc(1'b0, 0, 1'b0, 1'b1);
        chk("rr_second_ch", ch, 3);
        chk("rr_second_word", word, 3);
        cyc(1'b0, 0, 1'b0, 1'b1);
        chk("rr_third_ch", ch, 6);
        chk("rr_third_word", word, 6);
        cyc(1'b0, 0, 1'b0, 1'b1);
        chk("rr_empty", valid, 0);

        // backpressure stability and overrun on ch0
        send_word(1, 7, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 0, 1'b0, 1'b0);
            chk("bp_word", word, 7);
            chk("bp_ch", ch, 1);
            chk("bp_valid", valid, 1);
        end
        send_word(0, 5, 1'b0);
        send_word(0, 9, 1'b0);
        chk("ovr_flag", overflow, 8'h01);
        cyc(1'b0, 0, 1'b0, 1'b1);
        chk("ovr_kept_word", word, 5);
        chk("ovr_kept_ch", ch, 0);
        cyc(1'b0, 0, 1'b0, 1'b1);
        chk("ovr_empty", valid, 0);

        // same-edge reload on ch4
        send_word(3, 2, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0);
        send_word(4, 'hA, 1'b0);
        cyc(1'b1, 4, 1'b1, 1'b0);
        cyc(1'b1, 4, 1'b1, 1'b0);
        cyc(1'b1, 4, 1'b0, 1'b0);
        cyc(1'b1, 4, 1'b0, 1'b1);
        chk("same_ovf4", overflow[4], 0);
        chk("same_word_a", word, 'hA);
        chk("same_ch", ch, 4);
        cyc(1'b0, 0, 1'b0, 1'b1);
        chk("same_word_c", word, 'hC);
        chk("same_ch2", ch, 4);
        cyc(1'b0, 0, 1'b0, 1'b1);
        chk("same_empty", valid, 0);

        // interleaved ch2 / ch7 with stray bits on unselected lines
        b3 = 'h3; be = 'hE;
        for (int i = WORD - 1; i >= 0; i--) begin
            cyc(1'b1, 2, b3[i], 1'b1);
            cyc(1'b1, 7, be[i], 1'b1);
        end
        chk("ilv_word2", word, 'h3);
        chk("ilv_ch2", ch, 2);
        cyc(1'b0, 0, 1'b0, 1'b1);
        chk("ilv_word7", word, 'hE);
        chk("ilv_ch7", ch, 7);
        cyc(1'b0, 0, 1'b0, 1'b1);
        chk("ilv_empty", valid, 0);

        // reset mid-word, then exactly one word from 4 fresh strobes
        cyc(1'b1, 2, 1'b1, 1'b1);
        cyc(1'b1, 2, 1'b1, 1'b1);
        async_reset();
        send_word(2, 9, 1'b1);
        chk("midrst_pre", valid, 0);
        cyc(1'b0, 0, 1'b0, 1'b1);
        chk("midrst_word", word, 9);
        chk("midrst_ch", ch, 2);
        cyc(1'b0, 0, 1'b0, 1'b1);
        chk("midrst_once", valid, 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) async_reset();
            cyc(1'($urandom_range(0, 3) != 0), $urandom_range(0, 7),
                1'($urandom), 1'($urandom_range(0, 2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
